i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) endpoint, the responding end of the bus driven by the team's I2C master. Oversamples `scl`/`sda` on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and then either delivers written bytes to the fabric or serialises fabric-supplied bytes back to the master. It runs in standard and fast mode (≤400 kHz) at a 100 MHz system clock, with no clock stretching.

## Interface
- `SLAVE_ADDR`, 7'h42, 7-bit address this target answers to.
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `scl`  in  1  bus clock; input only, never driven.
- `sda`  inout  1  bus data, open-drain: driven `0` or `1'bz`, never `1`.
- `rx_data`  out  8  last byte written by the master, MSB first on the wire.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `tx_data`  in  8  byte to return on a read; sampled when the byte starts.
- `tx_req`  out  1  one-cycle pulse requesting the next `tx_data`.
- `busy`  out  1  high while addressed, from the address match to STOP or repeated START.
- `nack_rx`  out  1  one-cycle pulse when the master NACKs a read byte.

## Operation
- Input conditioning: `scl` and `sda` each pass through a 2-flop synchroniser and then a history flop. Edges and levels are taken only from the synchronised copies.
- START: synced `sda` 1→0 while synced `scl`=1. STOP: synced `sda` 0→1 while synced `scl`=1. Both are honoured in every state, including the slave's own ACK or data slots.
- STOP sends the FSM to IDLE. START, including a repeated START, sends it to ADDR with the bit counter reset. Either one releases `sda` and clears `busy`.
- States:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits on `scl` rises. If bits[7:1]==`SLAVE_ADDR`, go to ADDR_ACK. Otherwise go to WAIT_STOP.
  - ADDR_ACK: `sda` is driven low for the 9th clock. If R/W=0, go to WRITE. If R/W=1, go to READ.
  - WRITE: shifts 8 bits in, then goes to WR_ACK. The slave always ACKs; there is no back-pressure.
  - WR_ACK: drives the ACK, then returns to WRITE.
  - READ: presents `tx_data` bits 7..0, then goes to RD_ACK.
  - RD_ACK: `sda` is released and the master's bit is sampled. 0 (ACK) goes to READ. 1 (NACK) gives a `nack_rx` pulse and goes to WAIT_STOP.
  - WAIT_STOP: `sda` is released; only START or STOP is acted on.
- Data is sampled on the detected `scl` rise. The slave's `sda` drive changes only on the detected `scl` fall, so it always changes while SCL is low and never produces a false START or STOP.
- A 3-bit bit counter runs 7→0. The 8-bit shift register shifts left with the new bit in the LSB.
- General-call address 0x00 is not matched unless `SLAVE_ADDR`=0.

## Timing
- Reset values: `sda` released (Z), `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, `nack_rx`=0, state IDLE.
- Event detection latency is 3 `clk` cycles after the pin edge: 2 sync stages plus 1 history stage.
- `busy` rises in the cycle after the 8th address-bit `scl` rise detection when the address matches.
- `rx_valid`:
  - Pulses on the cycle after the 8th data-bit `scl` rise detection.
  - `rx_data` is updated on that same cycle and holds until the next byte.
- `tx_req` and `tx_data` sampling:
  - `tx_req` pulses on the `scl` rise detection of the 9th (ACK) clock, both after the address ACK and after a master ACK.
  - `tx_data` must be stable by the next `scl` fall detection, where it is loaded; bit 7 is driven on that same cycle.
  - At 400 kHz this gives at least 100 `clk` cycles of margin.
- ACK slot: `sda` is pulled low from the `scl` fall detection after bit 0 until the following `scl` fall detection.
- After the read ACK slot, `sda` is released on the `scl` fall detection ending bit 0. It is then either reloaded or left released.
- Reset mid-transfer releases `sda` immediately; this is asynchronous.

## Test plan
- Write, matched: START, 0x84 (0x42,W), 0xA5, STOP → ACK on the address and data slots; one `rx_valid` with `rx_data`=8'hA5; `busy` 1 then 0 after STOP.
- Address mismatch: START, 0x86, 0x11, STOP → `sda` never driven; no `rx_valid`; `busy` stays 0.
- Read, two bytes: START, 0x85; `tx_data`=8'h3C then 8'hC3 on successive `tx_req`; master ACK then NACK → wire bytes 0x3C, 0xC3; 2 `tx_req`; 1 `nack_rx`; `sda` released afterwards.
- Repeated START: write 0x84, 0x01, then Sr, 0x85, read 1 byte with NACK, STOP → `rx_data`=8'h01; then a read of `tx_data`; `busy` drops at Sr and rises again at the re-match.
- Abort: STOP injected after data bit 4 of a write → FSM returns to IDLE; no `rx_valid`; `sda` released.
- Reset asserted during the ACK slot → `sda` goes Z within the same cycle; all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target endpoint with a fixed 7-bit address. Oversamples
//               scl/sda on the system clock, detects START/STOP, ACKs the
//               address and written bytes, delivers written bytes to the
//               fabric and serialises fabric-supplied bytes on reads.
//               No clock stretching.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               scl      - bus clock (input only)
//               sda      - bus data, open-drain (drives 0 or Z)
//               rx_data  - last byte written by the master
//               rx_valid - one-cycle pulse when rx_data updates
//               tx_data  - byte to return on a read, loaded at byte start
//               tx_req   - one-cycle pulse requesting the next tx_data
//               busy     - high while addressed (match to STOP / Sr)
//               nack_rx  - one-cycle pulse when the master NACKs a read byte
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_rx
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_WRITE     = 3'd3;
    localparam logic [2:0] c_WR_ACK    = 3'd4;
    localparam logic [2:0] c_READ      = 3'd5;
    localparam logic [2:0] c_RD_ACK    = 3'd6;
    localparam logic [2:0] c_WAIT_STOP = 3'd7;

    // Synchroniser stages plus a history flop per line. They reset to 1 (the
    // idle bus level) so leaving reset never looks like a START.
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_armed;   // ACK-slot phase: first fall seen / master ACK seen
    logic       r_rw;
    logic       r_sda_oe;

    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_bit;
    logic [7:0] w_shift_in;

    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
    assign w_bit      = r_sda_s2;
    assign w_shift_in = {r_shift[6:0], w_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 3'd7;
            r_shift   <= 8'h00;
            r_armed   <= 1'b0;
            r_rw      <= 1'b0;
            r_sda_oe  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            nack_rx   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            nack_rx  <= 1'b0;
            // Bus conditions override whatever the FSM is doing, including
            // our own ACK or data slots.
            if (w_stop) begin
                r_state  <= c_IDLE;
                r_sda_oe <= 1'b0;
                busy     <= 1'b0;
            end else if (w_start) begin
                r_state   <= c_ADDR;
                r_bit_cnt <= 3'd7;
                r_sda_oe  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    c_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                if (r_shift[6:0] == SLAVE_ADDR) begin
                                    r_state <= c_ADDR_ACK;
                                    r_armed <= 1'b0;
                                    r_rw    <= w_bit;
                                    busy    <= 1'b1;
                                end else begin
                                    r_state <= c_WAIT_STOP;
                                end
                            end
                        end
                    end
                    c_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_armed) begin
                                r_sda_oe <= 1'b1;
                                r_armed  <= 1'b1;
                            end else begin
                                r_bit_cnt <= 3'd7;
                                if (r_rw) begin
                                    r_shift  <= tx_data;
                                    r_sda_oe <= ~tx_data[7];
                                    r_state  <= c_READ;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= c_WRITE;
                                end
                            end
                        end else if (w_scl_rise && r_armed && r_rw) begin
                            tx_req <= 1'b1;
                        end
                    end
                    c_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                rx_data  <= w_shift_in;
                                rx_valid <= 1'b1;
                                r_armed  <= 1'b0;
                                r_state  <= c_WR_ACK;
                            end
                        end
                    end
                    c_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_armed) begin
                                r_sda_oe <= 1'b1;
                                r_armed  <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd7;
                                r_state   <= c_WRITE;
                            end
                        end
                    end
                    c_READ: begin
                        // Bit 7 went out when the byte was loaded; each fall
                        // advances to the next bit, the fall after bit 0
                        // hands the line to the master for its ACK.
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_armed  <= 1'b0;
                                r_state  <= c_RD_ACK;
                            end else begin
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_oe  <= ~r_shift[6];
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    c_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_bit) begin
                                tx_req  <= 1'b1;
                                r_armed <= 1'b1;
                            end else begin
                                nack_rx <= 1'b1;
                                r_state <= c_WAIT_STOP;
                            end
                        end else if (w_scl_fall && r_armed) begin
                            r_shift   <= tx_data;
                            r_sda_oe  <= ~tx_data[7];
                            r_bit_cnt <= 3'd7;
                            r_state   <= c_READ;
                        end
                    end
                    c_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Self-checking bench for i2c_slave. A behavioural bus master
//               drives scl/sda; a table of write transactions is applied in
//               a loop, followed by hand-written read, repeated-START, abort
//               and reset-during-ACK sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int c_Q = 20;   // quarter bit period in clk cycles

    logic       clk;
    logic       reset_n;
    logic       r_scl;
    logic       r_m_oe;
    logic [7:0] r_tx_data;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       nack_rx;

    assign sda = r_m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (r_scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (r_tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .nack_rx  (nack_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Event counters, written only by the monitor below.
    int rxv_cnt  = 0;
    int txr_cnt  = 0;
    int nack_cnt = 0;
    int busy_cnt = 0;
    int drv_cnt  = 0;
    int tx_idx   = 0;
    logic [7:0] tx_q [3];

    initial begin
        tx_q[0] = 8'h3C;
        tx_q[1] = 8'hC3;
        tx_q[2] = 8'h96;
        r_tx_data = 8'h00;
    end

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (nack_rx) nack_cnt++;
        if (busy) busy_cnt++;
        if (!r_m_oe && sda === 1'b0) drv_cnt++;
        if (tx_req) begin
            txr_cnt++;
            if (tx_idx < 3) begin
                r_tx_data = tx_q[tx_idx];
                tx_idx++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wq();
        #(c_Q * 10);
    endtask

    task automatic set_sda(input logic b);
        r_m_oe = ~b;
    endtask

    task automatic bus_start();
        set_sda(1'b1); wq();
        r_scl = 1'b1;  wq();
        set_sda(1'b0); wq();
        r_scl = 1'b0;  wq();
    endtask

    task automatic bus_stop();
        set_sda(1'b0); wq();
        r_scl = 1'b1;  wq();
        set_sda(1'b1); wq();
    endtask

    task automatic write_bit(input logic b);
        set_sda(b);   wq();
        r_scl = 1'b1; wq();
        wq();
        r_scl = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        set_sda(1'b1); wq();
        r_scl = 1'b1;  wq();
        b = sda;       wq();
        r_scl = 1'b0;  wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       match;   // hand-decoded: addr[7:1]==7'h42 and addr[0]==0
    } wr_vec_t;

    wr_vec_t    vecs [6];
    logic       ack;
    logic [7:0] b1, b2;
    logic [7:0] exp_rx;
    int         s_rxv, s_txr, s_nack, s_busy, s_drv;

    initial begin
        vecs[0] = '{8'h84, 8'hA5, 1'b1};
        vecs[1] = '{8'h86, 8'h11, 1'b0};
        vecs[2] = '{8'h84, 8'h00, 1'b1};
        vecs[3] = '{8'h00, 8'h5A, 1'b0};
        vecs[4] = '{8'h84, 8'hFF, 1'b1};
        vecs[5] = '{8'h04, 8'h33, 1'b0};

        reset_n = 1'b0;
        r_scl   = 1'b1;
        r_m_oe  = 1'b0;
        exp_rx  = 8'h00;
        #2;
        #50;
        check("reset_sda",      {31'd0, sda},      32'd1);
        check("reset_rx_data",  {24'd0, rx_data},  32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_tx_req",   {31'd0, tx_req},   32'd0);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_nack_rx",  {31'd0, nack_rx},  32'd0);
        reset_n = 1'b1;
        wq();

        // ---------------- table-driven write transactions ----------------
        for (int v = 0; v < 6; v++) begin
            s_rxv = rxv_cnt; s_busy = busy_cnt; s_drv = drv_cnt;
            bus_start();
            write_byte(vecs[v].addr, ack);
            check($sformatf("v%0d_addr_ack", v), {31'd0, ack}, {31'd0, ~vecs[v].match});
            write_byte(vecs[v].data, ack);
            check($sformatf("v%0d_data_ack", v), {31'd0, ack}, {31'd0, ~vecs[v].match});
            bus_stop();
            wq();
            if (vecs[v].match) exp_rx = vecs[v].data;
            check($sformatf("v%0d_rx_valid_cnt", v), rxv_cnt - s_rxv, {31'd0, vecs[v].match});
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, exp_rx});
            check($sformatf("v%0d_busy_seen", v), {31'd0, (busy_cnt != s_busy)}, {31'd0, vecs[v].match});
            check($sformatf("v%0d_sda_driven", v), {31'd0, (drv_cnt != s_drv)}, {31'd0, vecs[v].match});
            check($sformatf("v%0d_busy_after_stop", v), {31'd0, busy}, 32'd0);
        end

        // ---------------- read, two bytes, ACK then NACK ----------------
        s_txr = txr_cnt; s_nack = nack_cnt;
        bus_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd1);
        read_byte(b1, 1'b0);
        read_byte(b2, 1'b1);
        wq();
        check("rd_sda_released_after_nack", {31'd0, sda}, 32'd1);
        bus_stop();
        wq();
        check("rd_byte0", {24'd0, b1}, 32'h3C);
        check("rd_byte1", {24'd0, b2}, 32'hC3);
        check("rd_tx_req_cnt", txr_cnt - s_txr, 32'd2);
        check("rd_nack_cnt", nack_cnt - s_nack, 32'd1);
        check("rd_sda_released", {31'd0, sda}, 32'd1);
        check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

        // ---------------- repeated START: write then read ----------------
        s_rxv = rxv_cnt; s_txr = txr_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("sr_addr_w_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h01, ack);
        check("sr_data_ack", {31'd0, ack}, 32'd0);
        check("sr_busy_before_sr", {31'd0, busy}, 32'd1);
        bus_start();
        check("sr_busy_after_sr", {31'd0, busy}, 32'd0);
        write_byte(8'h85, ack);
        check("sr_addr_r_ack", {31'd0, ack}, 32'd0);
        check("sr_busy_rematch", {31'd0, busy}, 32'd1);
        read_byte(b1, 1'b1);
        bus_stop();
        wq();
        check("sr_rx_data", {24'd0, rx_data}, 32'h01);
        check("sr_rx_valid_cnt", rxv_cnt - s_rxv, 32'd1);
        check("sr_read_byte", {24'd0, b1}, 32'h96);
        check("sr_tx_req_cnt", txr_cnt - s_txr, 32'd1);

        // ---------------- abort: STOP after data bit 4 ----------------
        s_rxv = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("ab_addr_ack", {31'd0, ack}, 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop();
        wq();
        check("ab_rx_valid_cnt", rxv_cnt - s_rxv, 32'd0);
        check("ab_rx_data_held", {24'd0, rx_data}, 32'h01);
        check("ab_sda_released", {31'd0, sda}, 32'd1);
        check("ab_busy", {31'd0, busy}, 32'd0);
        // Back in IDLE: a fresh write must work normally.
        bus_start();
        write_byte(8'h84, ack);
        check("ab_next_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack);
        check("ab_next_data_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        wq();
        check("ab_next_rx_data", {24'd0, rx_data}, 32'h5A);

        // ---------------- reset asserted during the ACK slot ----------------
        bus_start();
        write_byte(8'h84, ack);
        for (int i = 7; i >= 0; i--) write_bit(i[0]);
        set_sda(1'b1);
        #(c_Q * 5);
        check("rst_ack_driven", {31'd0, sda}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("rst_sda_z", {31'd0, sda}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_nack_rx", {31'd0, nack_rx}, 32'd0);
        r_scl = 1'b1;
        wq();
        reset_n = 1'b1;
        wq();
        check("rst_sda_after_release", {31'd0, sda}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
